// File: rtl/fft_fp2int_seq_pkg.sv
// Shared types and constants for the FFT fp->int frame sequencer and its result FIFO.
// Used by both fft_fp2int_sequencer and fft_fp2int_result_fifo.
package fft_fp2int_seq_pkg;

  localparam int LANES    = 4;
  localparam int SAMPLE_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [LANES-1:0][SAMPLE_W-1:0] data;
    logic                           last;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fft_fp2int_result_fifo.sv
// First-word-fall-through result FIFO with occupancy count.
// Read data is forced to zero while empty so stale entries never reach the port.
module fft_fp2int_result_fifo
  import fft_fp2int_seq_pkg::*;
#(
  parameter int WIDTH = BEAT_W,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_rd   = rd_en && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fft_fp2int_sequencer.sv
// Valid/ready frame sequencer around the handshake-less fft_fp2int_converter.
// Define FFT_FP2INT_SEQ_PERF_CNT_EN to add the stall_cnt / credit_stall_cnt outputs.
//
//   state | meaning
//   IDLE  | waiting for start with a non-zero frame length
//   RUN   | accepting input beats, issuing them to the converter
//   DRAIN | all beats issued, waiting for the last output handshake
module fft_fp2int_sequencer
  import fft_fp2int_seq_pkg::*;
#(
  parameter int CVT_LAT    = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 12
) (
  input  logic                s_axi_aclk,
  input  logic                s_axi_areset,
  input  logic                start,
  input  logic [LEN_W-1:0]    cfg_frame_len,
  output logic                busy,
  output logic                frame_done,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] in_data_0,
  input  logic [SAMPLE_W-1:0] in_data_1,
  input  logic [SAMPLE_W-1:0] in_data_2,
  input  logic [SAMPLE_W-1:0] in_data_3,
  output logic [SAMPLE_W-1:0] cvt_data_0,
  output logic [SAMPLE_W-1:0] cvt_data_1,
  output logic [SAMPLE_W-1:0] cvt_data_2,
  output logic [SAMPLE_W-1:0] cvt_data_3,
  input  logic [SAMPLE_W-1:0] cvt_result_0,
  input  logic [SAMPLE_W-1:0] cvt_result_1,
  input  logic [SAMPLE_W-1:0] cvt_result_2,
  input  logic [SAMPLE_W-1:0] cvt_result_3,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SAMPLE_W-1:0] out_data_0,
  output logic [SAMPLE_W-1:0] out_data_1,
  output logic [SAMPLE_W-1:0] out_data_2,
  output logic [SAMPLE_W-1:0] out_data_3,
  output logic                out_last,
  output logic [LEN_W-1:0]    beat_cnt
`ifdef FFT_FP2INT_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]         stall_cnt,
  output logic [31:0]         credit_stall_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  seq_state_e                     state;
  seq_state_e                     state_nxt;
  logic [LEN_W-1:0]               frame_len;
  logic [LANES-1:0][SAMPLE_W-1:0] cvt_data;
  logic [CVT_LAT-1:0]             sr_vld;
  logic [CVT_LAT-1:0]             sr_last;
  logic [CW-1:0]                  inflight_count;
  logic [CW-1:0]                  fifo_count;
  logic [CW:0]                    credit_used;
  logic                           start_acc;
  logic                           issue;
  logic                           issue_last;
  logic                           capture;
  logic                           out_hs_last;
  logic                           fifo_empty;
  beat_t                          wr_beat;
  beat_t                          rd_beat;

  assign start_acc   = (state == IDLE) && start && (cfg_frame_len != '0);
  assign issue       = in_valid && in_ready;
  assign issue_last  = issue && (beat_cnt == frame_len - LEN_W'(1));
  assign capture     = sr_vld[CVT_LAT-1];
  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight_count};
  assign out_valid   = !fifo_empty;
  assign out_last    = rd_beat.last;
  assign out_hs_last = out_valid && out_ready && out_last;

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) state <= IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_acc)   state_nxt = RUN;
      RUN:     if (issue_last)  state_nxt = DRAIN;
      DRAIN:   if (out_hs_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Credit = FIFO entries + beats inside the converter; never issue more than the FIFO can hold.
  always_comb begin
    busy       = 1'b0;
    in_ready   = 1'b0;
    frame_done = 1'b0;
    case (state)
      RUN: begin
        busy     = 1'b1;
        in_ready = (credit_used < (CW+1)'(FIFO_DEPTH)) && (beat_cnt < frame_len);
      end
      DRAIN: begin
        busy       = 1'b1;
        frame_done = out_hs_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      frame_len <= '0;
      beat_cnt  <= '0;
      cvt_data  <= '0;
    end else begin
      if (start_acc) begin
        frame_len <= cfg_frame_len;
        beat_cnt  <= '0;
      end else if (issue) begin
        beat_cnt <= beat_cnt + LEN_W'(1);
      end
      if (issue) cvt_data <= {in_data_3, in_data_2, in_data_1, in_data_0};
    end
  end

  // Tap CVT_LAT-1 lines up with the converter result for the beat issued CVT_LAT edges earlier.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      sr_vld         <= '0;
      sr_last        <= '0;
      inflight_count <= '0;
    end else begin
      sr_vld[0]  <= issue;
      sr_last[0] <= issue_last;
      for (int i = 1; i < CVT_LAT; i++) begin
        sr_vld[i]  <= sr_vld[i-1];
        sr_last[i] <= sr_last[i-1];
      end
      case ({issue, capture})
        2'b10:   inflight_count <= inflight_count + CW'(1);
        2'b01:   inflight_count <= inflight_count - CW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_beat.data[0] = cvt_result_0;
    wr_beat.data[1] = cvt_result_1;
    wr_beat.data[2] = cvt_result_2;
    wr_beat.data[3] = cvt_result_3;
    wr_beat.last    = sr_last[CVT_LAT-1];
  end

  fft_fp2int_result_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk     (s_axi_aclk),
    .rst     (s_axi_areset),
    .wr_en   (capture),
    .wr_data (wr_beat),
    .rd_en   (out_ready),
    .rd_data (rd_beat),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign cvt_data_0 = cvt_data[0];
  assign cvt_data_1 = cvt_data[1];
  assign cvt_data_2 = cvt_data[2];
  assign cvt_data_3 = cvt_data[3];
  assign out_data_0 = rd_beat.data[0];
  assign out_data_1 = rd_beat.data[1];
  assign out_data_2 = rd_beat.data[2];
  assign out_data_3 = rd_beat.data[3];

`ifdef FFT_FP2INT_SEQ_PERF_CNT_EN
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      stall_cnt        <= '0;
      credit_stall_cnt <= '0;
    end else if (start_acc) begin
      stall_cnt        <= '0;
      credit_stall_cnt <= '0;
    end else begin
      if (out_valid && !out_ready)
        stall_cnt <= sat_inc(stall_cnt);
      if ((state == RUN) && in_valid && !in_ready)
        credit_stall_cnt <= sat_inc(credit_stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_fft_fp2int_sequencer.sv
// Directed bench for fft_fp2int_sequencer with a one-stage inverting converter model (CVT_LAT=2).
// Define FFT_FP2INT_SEQ_PERF_CNT_EN to also exercise the stall counters.
module tb_fft_fp2int_sequencer;

  localparam int CVT_LAT    = 2;
  localparam int FIFO_DEPTH = 8;
  localparam int LEN_W      = 12;

  logic             clk;
  logic             s_axi_areset;
  logic             start;
  logic [LEN_W-1:0] cfg_frame_len;
  logic             busy, frame_done;
  logic             in_valid, in_ready;
  logic [63:0]      in_data_0, in_data_1, in_data_2, in_data_3;
  logic [63:0]      cvt_data_0, cvt_data_1, cvt_data_2, cvt_data_3;
  logic [63:0]      cvt_result_0, cvt_result_1, cvt_result_2, cvt_result_3;
  logic             out_valid, out_ready, out_last;
  logic [63:0]      out_data_0, out_data_1, out_data_2, out_data_3;
  logic [LEN_W-1:0] beat_cnt;
`ifdef FFT_FP2INT_SEQ_PERF_CNT_EN
  logic [31:0]      stall_cnt, credit_stall_cnt;
`endif

  fft_fp2int_sequencer #(
    .CVT_LAT    (CVT_LAT),
    .FIFO_DEPTH (FIFO_DEPTH),
    .LEN_W      (LEN_W)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_areset  (s_axi_areset),
    .start         (start),
    .cfg_frame_len (cfg_frame_len),
    .busy          (busy),
    .frame_done    (frame_done),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data_0     (in_data_0),
    .in_data_1     (in_data_1),
    .in_data_2     (in_data_2),
    .in_data_3     (in_data_3),
    .cvt_data_0    (cvt_data_0),
    .cvt_data_1    (cvt_data_1),
    .cvt_data_2    (cvt_data_2),
    .cvt_data_3    (cvt_data_3),
    .cvt_result_0  (cvt_result_0),
    .cvt_result_1  (cvt_result_1),
    .cvt_result_2  (cvt_result_2),
    .cvt_result_3  (cvt_result_3),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data_0    (out_data_0),
    .out_data_1    (out_data_1),
    .out_data_2    (out_data_2),
    .out_data_3    (out_data_3),
    .out_last      (out_last),
    .beat_cnt      (beat_cnt)
`ifdef FFT_FP2INT_SEQ_PERF_CNT_EN
    ,
    .stall_cnt        (stall_cnt),
    .credit_stall_cnt (credit_stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Converter model: one register stage after cvt_data, result = bitwise inverse.
  always_ff @(posedge clk) begin
    cvt_result_0 <= ~cvt_data_0;
    cvt_result_1 <= ~cvt_data_1;
    cvt_result_2 <= ~cvt_data_2;
    cvt_result_3 <= ~cvt_data_3;
  end

  typedef struct {
    logic [255:0] d;
    logic         last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   seq = 0;
  int   cyc = 0;
  int   cur_len = 0;
  int   in_cnt, out_cnt, last_cnt, done_cnt, first_in, first_ov;
  int   saved_done;

  function automatic logic [63:0] mk(input int s, input int k);
    return {8'(k + 1), 24'(s), 8'(k + 'h50), 24'(s ^ 'h5A5A5A)};
  endfunction

  function automatic bit rb(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit iv, input bit ordy);
    exp_t e;
    bit   in_hs, out_hs;
    @(posedge clk);
    #1;
    in_valid  = iv;
    out_ready = ordy;
    in_data_0 = mk(seq, 0);
    in_data_1 = mk(seq, 1);
    in_data_2 = mk(seq, 2);
    in_data_3 = mk(seq, 3);
    @(negedge clk);
    in_hs  = in_valid && in_ready;
    out_hs = out_valid && out_ready;
    if (out_valid && first_ov < 0) first_ov = cyc;
    if (in_hs) begin
      e.d    = {~mk(seq, 3), ~mk(seq, 2), ~mk(seq, 1), ~mk(seq, 0)};
      e.last = (in_cnt == cur_len - 1);
      exp_q.push_back(e);
      if (first_in < 0) first_in = cyc;
      in_cnt++;
      seq++;
    end
    if (out_hs) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL sb_unexpected_output observed=%0h expected=none",
               {out_data_3, out_data_2, out_data_1, out_data_0});
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_data", {out_data_3, out_data_2, out_data_1, out_data_0}, e.d);
        chk("out_last", out_last, e.last);
      end
      out_cnt++;
      if (out_last) last_cnt++;
    end
    if (frame_done) done_cnt++;
    cyc++;
  endtask

  task automatic pulse(input int len, input bit new_frame);
    @(posedge clk);
    #1;
    start         = 1'b1;
    cfg_frame_len = LEN_W'(len);
    in_valid      = 1'b0;
    out_ready     = 1'b0;
    if (new_frame) begin
      cur_len  = len;
      in_cnt   = 0;
      out_cnt  = 0;
      last_cnt = 0;
      done_cnt = 0;
      first_in = -1;
      first_ov = -1;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input int len, input int ivp, input int orp, input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      step(rb(ivp), rb(orp));
      n++;
    end
    checks++;
    assert (done_cnt != 0) else begin
      failures++;
      $error("FAIL frame_timeout observed=no_frame_done expected=frame_done within %0d cycles", budget);
    end
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("frame_done_once", done_cnt, 1);
    chk("out_count", out_cnt, len);
    chk("last_count", last_cnt, 1);
    chk("beat_cnt_final", beat_cnt, len);
    chk("busy_after_frame", busy, 0);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    s_axi_areset  = 1'b1;
    start         = 1'b0;
    cfg_frame_len = '0;
    in_valid      = 1'b0;
    out_ready     = 1'b0;
    in_data_0     = '0;
    in_data_1     = '0;
    in_data_2     = '0;
    in_data_3     = '0;
    in_cnt = 0; out_cnt = 0; last_cnt = 0; done_cnt = 0; first_in = -1; first_ov = -1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_cvt_data", {cvt_data_3, cvt_data_2, cvt_data_1, cvt_data_0}, 0);
    s_axi_areset = 1'b0;

    // Basic frame, latency
    pulse(4, 1);
    run_frame(4, 100, 100, 100);
    chk("first_out_latency", first_ov - first_in, 3);

    // Backpressure: credit stops input at FIFO_DEPTH beats
    pulse(20, 1);
    repeat (15) step(1'b1, 1'b0);
    chk("bp_accepted", in_cnt, FIFO_DEPTH);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    run_frame(20, 100, 100, 200);

    // Random traffic, back-to-back frames
    for (int f = 0; f < 10; f++) begin
      pulse(100, 1);
      run_frame(100, 50, 50, 2000);
    end

    // Zero-length start ignored
    saved_done = done_cnt;
    pulse(0, 0);
    repeat (3) step(1'b0, 1'b1);
    chk("len0_busy", busy, 0);
    chk("len0_no_done", done_cnt, saved_done);
    chk("len0_beat_cnt_kept", beat_cnt, 100);

    // Start while busy ignored
    pulse(3, 1);
    step(1'b1, 1'b1);
    pulse(7, 0);
    run_frame(3, 100, 100, 100);

    // Single-beat frame
    pulse(1, 1);
    run_frame(1, 100, 100, 100);

    // Reset mid-frame
    pulse(10, 1);
    repeat (5) step(1'b1, 1'b0);
    chk("mid_accepted", in_cnt, 5);
    chk("mid_out_valid_before", out_valid, 1);
    s_axi_areset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_frame_done", frame_done, 0);
    chk("mid_rst_beat_cnt", beat_cnt, 0);
    chk("mid_rst_out_data", {out_data_3, out_data_2, out_data_1, out_data_0}, 0);
    chk("mid_rst_cvt_data", {cvt_data_3, cvt_data_2, cvt_data_1, cvt_data_0}, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    s_axi_areset = 1'b0;
    pulse(3, 1);
    run_frame(3, 100, 100, 100);

`ifdef FFT_FP2INT_SEQ_PERF_CNT_EN
    pulse(1, 1);
    step(1'b1, 1'b0);
    repeat (14) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("stall_cnt_12", stall_cnt, 12);
    run_frame(1, 100, 100, 100);
    pulse(2, 1);
    step(1'b0, 1'b0);
    chk("stall_cnt_cleared", stall_cnt, 0);
    chk("credit_stall_cleared", credit_stall_cnt, 0);
    run_frame(2, 100, 100, 100);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
